write_back_stage: RTL

Final pipeline stage of the processor datapath; the return path to the register file for the operand path that feeds the ALU. Takes one retired instruction per handshake and selects the write-back value: ALU result, memory load data, or a merged LLW/LHW half-word. CALL writes the link address. Produces a single-cycle register-file write strobe and stalls upstream while a load waits for memory.

---
 rtl/write_back_stage.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/write_back_stage.sv
// Write-back stage: selects ALU/load/LLW/LHW/CALL data and emits a one-cycle register-file write.
// Optional load timeout enabled by defining WB_MEM_TIMEOUT_EN.
module write_back_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iValid,
  output logic              oReady,
  input  logic              iRegWrite,
  input  logic              iCallCmd,
  input  logic [1:0]        iWbSel,
  input  logic [REG_AW-1:0] iDestReg,
  input  logic [DATA_W-1:0] iAluResult,
  input  logic [DATA_W-1:0] iRegOld,
  input  logic [DATA_W-1:0] iPcNext,
  input  logic [DATA_W-1:0] iMemData,
  input  logic              iMemValid,
  output logic              oRegWe,
  output logic [REG_AW-1:0] oRegAddr,
  output logic [DATA_W-1:0] oRegData,
  output logic              oMemErr
);

  localparam int HALF = DATA_W / 2;
  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LLW  = 2'b10;
  localparam logic [1:0] SEL_LHW  = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } wbState_t;

  wbState_t          stateReg, stateNext;
  logic              regWeReg, regWeNext;
  logic [REG_AW-1:0] regAddrReg, regAddrNext;
  logic [DATA_W-1:0] regDataReg, regDataNext;
  logic              pendWeReg, pendWeNext;
  logic [REG_AW-1:0] pendAddrReg, pendAddrNext;

  logic              accept;
  logic              isLoad;
  logic              doWrite;
  logic [REG_AW-1:0] wrAddr;
  logic [DATA_W-1:0] selData;

`ifdef WB_MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] waitCntReg, waitCntNext;
  logic             memErrReg, memErrNext;
`endif

  assign oReady = (stateReg != WAIT_MEM);
  assign accept = iValid && oReady;

  // CALL overrides the select, so a CALL is never treated as a load.
  assign isLoad  = !iCallCmd && (iWbSel == SEL_LOAD);
  assign doWrite = iCallCmd || (iRegWrite && (iDestReg != '0));
  assign wrAddr  = iCallCmd ? {REG_AW{1'b1}} : iDestReg;

  always_comb begin
    selData = iAluResult;
    if (iCallCmd) begin
      selData = iPcNext;
    end else begin
      case (iWbSel)
        SEL_ALU: selData = iAluResult;
        SEL_LLW: selData = {iRegOld[DATA_W-1:HALF], iAluResult[HALF-1:0]};
        SEL_LHW: selData = {iAluResult[HALF-1:0], iRegOld[HALF-1:0]};
        default: selData = iAluResult;
      endcase
    end
  end

  always_comb begin
    stateNext    = stateReg;
    regWeNext    = 1'b0;
    regAddrNext  = regAddrReg;
    regDataNext  = regDataReg;
    pendWeNext   = pendWeReg;
    pendAddrNext = pendAddrReg;
`ifdef WB_MEM_TIMEOUT_EN
    waitCntNext  = waitCntReg;
    memErrNext   = 1'b0;
`endif
    case (stateReg)
      IDLE, WRITE: begin
        stateNext = IDLE;
        if (accept) begin
          if (isLoad) begin
            stateNext    = WAIT_MEM;
            pendWeNext   = doWrite;
            pendAddrNext = wrAddr;
`ifdef WB_MEM_TIMEOUT_EN
            waitCntNext  = '0;
`endif
          end else begin
            stateNext = WRITE;
            regWeNext = doWrite;
            if (doWrite) begin
              regAddrNext = wrAddr;
              regDataNext = selData;
            end
          end
        end
      end
      WAIT_MEM: begin
        // Data arriving on the final counted cycle still wins over the timeout.
        if (iMemValid) begin
          stateNext = WRITE;
          regWeNext = pendWeReg;
          if (pendWeReg) begin
            regAddrNext = pendAddrReg;
            regDataNext = iMemData;
          end
`ifdef WB_MEM_TIMEOUT_EN
        end else if (waitCntReg == CNT_W'(TIMEOUT - 1)) begin
          stateNext  = IDLE;
          memErrNext = 1'b1;
        end else begin
          waitCntNext = waitCntReg + 1'b1;
`endif
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      stateReg    <= IDLE;
      regWeReg    <= 1'b0;
      regAddrReg  <= '0;
      regDataReg  <= '0;
      pendWeReg   <= 1'b0;
      pendAddrReg <= '0;
    end else begin
      stateReg    <= stateNext;
      regWeReg    <= regWeNext;
      regAddrReg  <= regAddrNext;
      regDataReg  <= regDataNext;
      pendWeReg   <= pendWeNext;
      pendAddrReg <= pendAddrNext;
    end
  end

`ifdef WB_MEM_TIMEOUT_EN
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      waitCntReg <= '0;
      memErrReg  <= 1'b0;
    end else begin
      waitCntReg <= waitCntNext;
      memErrReg  <= memErrNext;
    end
  end

  assign oMemErr = memErrReg;
`else
  logic unusedTimeout;
  assign unusedTimeout = (TIMEOUT != 0);
  assign oMemErr       = 1'b0;
`endif

  assign oRegWe   = regWeReg;
  assign oRegAddr = regAddrReg;
  assign oRegData = regDataReg;

endmodule
